// File: rtl/id_stage_v2.sv
// ID stage: registers the fetched instruction, reads operands, decodes the immediate and jumps,
// and inserts one bubble on load-use hazards. Optional write-back bypass: ID_WB_BYPASS_EN.
module id_stage_v2 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             IF_instruction,
  input  logic                    IF_valid,
  output logic                    IF_ready,
  input  logic [NREGS*DATA_W-1:0] rf_flat,
  input  logic                    flush,
  input  logic                    EX_ready,
  output logic                    ID_valid,
  output logic [31:0]             ID_instruction,
  output logic [DATA_W-1:0]       Readdata1,
  output logic [DATA_W-1:0]       Readdata2,
  output logic [DATA_W-1:0]       sign_extend,
  output logic                    jump,
  output logic [DATA_W-1:0]       jump_target,
  output logic                    illegal,
  input  logic                    wb_we,
  input  logic [4:0]              wb_addr,
  input  logic [DATA_W-1:0]       wb_data
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sext;
    logic              jump;
    logic [DATA_W-1:0] jt;
    logic              illegal;
  } id_regs_t;

  id_regs_t id_q, id_d, dec;

  logic [5:0]        if_op, id_op;
  logic [4:0]        if_rs, if_rt, id_rt;
  logic [DATA_W-1:0] imm_sext;
  logic              if_uses_rt, hazard, load_en;

`ifndef ID_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (idx == i[4:0]) v = rf_flat[i*DATA_W +: DATA_W];
    end
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == idx) v = wb_data;
`endif
    return v;
  endfunction

  assign if_op    = IF_instruction[31:26];
  assign if_rs    = IF_instruction[25:21];
  assign if_rt    = IF_instruction[20:16];
  assign imm_sext = {{(DATA_W-16){IF_instruction[15]}}, IF_instruction[15:0]};
  assign id_op    = id_q.instr[31:26];
  assign id_rt    = id_q.instr[20:16];

  // Only these IF formats actually read rt as a source.
  assign if_uses_rt = (if_op == OpRtype) || (if_op == OpSw) || (if_op == OpBne);
  assign hazard     = id_q.valid && (id_op == OpLw) && (id_rt != 5'd0) && IF_valid &&
                      ((id_rt == if_rs) || ((id_rt == if_rt) && if_uses_rt));
  assign load_en    = !id_q.valid || EX_ready;
  assign IF_ready   = !rst && (flush || (load_en && !hazard));

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.instr   = IF_instruction;
    dec.rd1     = rf_read(if_rs);
    dec.rd2     = rf_read(if_rt);
    unique case (if_op)
      OpRtype:           dec.sext = '0;
      OpLw, OpSw, OpAddi: dec.sext = imm_sext;
      OpBne:             dec.sext = imm_sext << 2;
      OpJ: begin
        dec.jump = 1'b1;
        dec.jt   = {{(DATA_W-28){1'b0}}, IF_instruction[25:0], 2'b00};
      end
      default: begin
        dec.illegal = 1'b1;
        dec.rd1     = '0;
        dec.rd2     = '0;
      end
    endcase
  end

  always_comb begin
    id_d = id_q;
    if (flush) begin
      id_d = '0;
    end else if (load_en) begin
      id_d = (hazard || !IF_valid) ? '0 : dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  assign ID_valid       = id_q.valid;
  assign ID_instruction = id_q.instr;
  assign Readdata1      = id_q.rd1;
  assign Readdata2      = id_q.rd2;
  assign sign_extend    = id_q.sext;
  assign jump           = id_q.jump;
  assign jump_target    = id_q.jt;
  assign illegal        = id_q.illegal;

endmodule
